// File: rtl/elevator_scheduler.sv
// rtl/elevator_scheduler.sv - SCAN-ordered call scheduler for a 4-floor elevator
module elevator_scheduler #(
    parameter int DOOR_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       stop,
    input  logic [3:0] call_req,
    input  logic [1:0] floor,
    output logic [1:0] target,
    output logic       target_valid,
    output logic       dir_up,
    output logic       door_open,
    output logic [3:0] pending,
    output logic [3:0] served_count
);

    typedef enum logic [1:0] {S_IDLE, S_MOVE, S_DOOR, S_HOLD} state_t;

    state_t     r_state;
    logic [3:0] r_pending;
    logic [1:0] r_target;
    logic       r_target_valid;
    logic       r_dir_up;
    logic       r_door_open;
    logic [3:0] r_served;
    logic [3:0] r_timer;

    logic       w_up_found;
    logic [1:0] w_up_tgt;
    logic       w_dn_found;
    logic [1:0] w_dn_tgt;
    logic       w_fwd_found;
    logic [1:0] w_fwd_tgt;
    logic       w_rev_found;
    logic [1:0] w_rev_tgt;
    logic [3:0] w_latch;
    logic [3:0] w_floor_mask;

    // Nearest pending floor strictly above / below the car.
    always_comb begin
        w_up_found = 1'b0;
        w_up_tgt   = floor;
        w_dn_found = 1'b0;
        w_dn_tgt   = floor;
        for (int i = 3; i >= 0; i--) begin
            if (i > int'(floor) && r_pending[i]) begin
                w_up_found = 1'b1;
                w_up_tgt   = 2'(i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (i < int'(floor) && r_pending[i]) begin
                w_dn_found = 1'b1;
                w_dn_tgt   = 2'(i);
            end
        end
    end

    assign w_fwd_found  = r_dir_up ? w_up_found : w_dn_found;
    assign w_fwd_tgt    = r_dir_up ? w_up_tgt   : w_dn_tgt;
    assign w_rev_found  = r_dir_up ? w_dn_found : w_up_found;
    assign w_rev_tgt    = r_dir_up ? w_dn_tgt   : w_up_tgt;
    assign w_latch      = r_pending | call_req;
    assign w_floor_mask = 4'd1 << floor;

    // Later non-blocking writes to r_pending override the plain latch, so clear wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_pending      <= 4'h0;
            r_target       <= 2'd0;
            r_target_valid <= 1'b0;
            r_dir_up       <= 1'b1;
            r_door_open    <= 1'b0;
            r_served       <= 4'h0;
            r_timer        <= 4'h0;
        end else begin
            r_pending <= w_latch;
            if (stop) begin
                r_state        <= S_HOLD;
                r_target_valid <= 1'b0;
                r_door_open    <= 1'b0;
                r_timer        <= 4'h0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (r_pending[floor]) begin
                            r_state        <= S_DOOR;
                            r_pending      <= w_latch & ~w_floor_mask;
                            r_served       <= r_served + 4'd1;
                            r_door_open    <= 1'b1;
                            r_target_valid <= 1'b0;
                            r_timer        <= 4'h0;
                        end else if (w_fwd_found) begin
                            r_state        <= S_MOVE;
                            r_target       <= w_fwd_tgt;
                            r_target_valid <= 1'b1;
                        end else if (w_rev_found) begin
                            r_state        <= S_MOVE;
                            r_dir_up       <= ~r_dir_up;
                            r_target       <= w_rev_tgt;
                            r_target_valid <= 1'b1;
                        end
                    end
                    S_MOVE: begin
                        if (floor == r_target) begin
                            r_state        <= S_DOOR;
                            r_pending      <= w_latch & ~w_floor_mask;
                            r_served       <= r_served + 4'd1;
                            r_door_open    <= 1'b1;
                            r_target_valid <= 1'b0;
                            r_timer        <= 4'h0;
                        end else if (w_fwd_found) begin
                            r_target <= w_fwd_tgt;
                        end
                    end
                    S_DOOR: begin
                        if (tick) begin
                            if (r_timer == 4'(DOOR_TICKS - 1)) begin
                                r_state     <= S_IDLE;
                                r_door_open <= 1'b0;
                                r_timer     <= 4'h0;
                            end else begin
                                r_timer <= r_timer + 4'd1;
                            end
                        end
                    end
                    S_HOLD: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign target       = r_target;
    assign target_valid = r_target_valid;
    assign dir_up       = r_dir_up;
    assign door_open    = r_door_open;
    assign pending      = r_pending;
    assign served_count = r_served;

endmodule
